// File: rtl/aurora_os_detector.sv
// Per-lane Aurora 8B/10B receive ordered-set detector: classifies the decoded character stream
// into ordered-set reports, extracts SUF/SNF payloads and forwards data characters.
module aurora_os_detector #(
    parameter int unsigned LANE_SEQ_LEN  = 3,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_is_k,
    input  logic                     rx_valid,
    input  logic                     rx_err,
    output logic [3:0]               os_type,
    output logic                     os_valid,
    output logic [7:0]               os_payload,
    output logic [7:0]               data_out,
    output logic                     data_valid,
    output logic                     err,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    typedef enum logic [3:0] {
        OS_NONE = 4'd0, OS_K = 4'd1, OS_R = 4'd2, OS_A = 4'd3, OS_I = 4'd4, OS_P = 4'd5,
        OS_SCP = 4'd6, OS_ECP = 4'd7, OS_CC = 4'd8, OS_SUF = 4'd9, OS_SNF = 4'd10,
        OS_SP = 4'd11, OS_SPA = 4'd12, OS_VER = 4'd13
    } ordered_sets_e;

    typedef enum logic [2:0] {S_IDLE, S_LANE, S_SCP2, S_ECP2, S_CC2, S_FLOW} state_e;

    localparam int unsigned CntW = $clog2(LANE_SEQ_LEN + 1);
    localparam logic [CntW:0] SeqLen = (CntW + 1)'(LANE_SEQ_LEN);

    function automatic ordered_sets_e lane_kind(input logic [7:0] b);
        case (b)
            8'h95:   return OS_SP;
            8'hB5:   return OS_SPA;
            8'h4A:   return OS_VER;
            default: return OS_NONE;
        endcase
    endfunction

    state_e                   state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [CntW:0]            cnt_inc;
    logic [7:0]               exp_q, exp_d;  // 0x00 marks "expected byte not yet seen"
    ordered_sets_e            flow_q, flow_d;
    ordered_sets_e            os_type_q, os_type_d;
    logic                     os_valid_q, os_valid_d;
    logic [7:0]               os_payload_q, os_payload_d;
    logic [7:0]               data_out_q, data_out_d;
    logic                     data_valid_q, data_valid_d;
    logic                     err_q, err_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                     redecode;
    logic [7:0]               second_char;
    ordered_sets_e            pair_kind;

    assign cnt_inc = {1'b0, cnt_q} + 1'b1;

    always_comb begin
        second_char = 8'hFC;
        pair_kind   = OS_CC;
        if (state_q == S_SCP2) begin
            second_char = 8'hFB;
            pair_kind   = OS_SCP;
        end else if (state_q == S_ECP2) begin
            second_char = 8'hFE;
            pair_kind   = OS_ECP;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        exp_d        = exp_q;
        flow_d       = flow_q;
        os_type_d    = OS_NONE;
        os_valid_d   = 1'b0;
        os_payload_d = '0;
        data_out_d   = '0;
        data_valid_d = 1'b0;
        err_d        = 1'b0;
        err_cnt_d    = err_cnt_q;
        redecode     = 1'b0;
        if (rx_valid) begin
            if (rx_err) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: redecode = 1'b1;
                    S_LANE: begin
                        // Any K aborts the sequence; 0xBC restarts it through the idle decode
                        if (rx_is_k) begin
                            redecode = 1'b1;
                        end else if (exp_q == 8'h00) begin
                            if (lane_kind(rx_data) != OS_NONE) begin
                                exp_d = rx_data;
                                cnt_d = CntW'(1);
                                if (SeqLen == (CntW + 1)'(1)) begin
                                    os_valid_d = 1'b1;
                                    os_type_d  = lane_kind(rx_data);
                                    state_d    = S_IDLE;
                                end
                            end else begin
                                data_valid_d = 1'b1;
                                data_out_d   = rx_data;
                                state_d      = S_IDLE;
                            end
                        end else if (rx_data == exp_q) begin
                            if (cnt_inc == SeqLen) begin
                                os_valid_d = 1'b1;
                                os_type_d  = lane_kind(exp_q);
                                state_d    = S_IDLE;
                            end else begin
                                cnt_d = cnt_inc[CntW-1:0];
                            end
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    S_SCP2, S_ECP2, S_CC2: begin
                        if (rx_is_k && rx_data == second_char) begin
                            os_valid_d = 1'b1;
                            os_type_d  = pair_kind;
                            state_d    = S_IDLE;
                        end else begin
                            err_d    = 1'b1;
                            redecode = 1'b1;
                        end
                    end
                    S_FLOW: begin
                        if (!rx_is_k) begin
                            os_valid_d   = 1'b1;
                            os_type_d    = flow_q;
                            os_payload_d = rx_data;
                            state_d      = S_IDLE;
                        end else begin
                            err_d    = 1'b1;
                            redecode = 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase

                if (redecode) begin
                    state_d = S_IDLE;
                    if (!rx_is_k) begin
                        data_valid_d = 1'b1;
                        data_out_d   = rx_data;
                    end else begin
                        case (rx_data)
                            8'h1C: begin os_valid_d = 1'b1; os_type_d = OS_R; end
                            8'h7C: begin os_valid_d = 1'b1; os_type_d = OS_A; end
                            8'h3C: begin os_valid_d = 1'b1; os_type_d = OS_I; end
                            8'hF7: begin os_valid_d = 1'b1; os_type_d = OS_P; end
                            8'hBC: begin
                                os_valid_d = 1'b1;
                                os_type_d  = OS_K;
                                state_d    = S_LANE;
                                cnt_d      = '0;
                                exp_d      = 8'h00;
                            end
                            8'h5C: state_d = S_SCP2;
                            8'hFD: state_d = S_ECP2;
                            8'hFC: state_d = S_CC2;
                            8'h9C: begin state_d = S_FLOW; flow_d = OS_SUF; end
                            8'hDC: begin state_d = S_FLOW; flow_d = OS_SNF; end
                            // Only one err per character even when already flagged above
                            default: err_d = 1'b1;
                        endcase
                    end
                end
            end
            if (err_d && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            exp_q        <= 8'h00;
            flow_q       <= OS_SUF;
            os_type_q    <= OS_NONE;
            os_valid_q   <= 1'b0;
            os_payload_q <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            exp_q        <= exp_d;
            flow_q       <= flow_d;
            os_type_q    <= os_type_d;
            os_valid_q   <= os_valid_d;
            os_payload_q <= os_payload_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign os_type    = os_type_q;
    assign os_valid   = os_valid_q;
    assign os_payload = os_payload_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_aurora_os_detector.sv
// Randomized scoreboard bench for aurora_os_detector: a pattern-matching reference model queues
// expected pulses, a negedge monitor pops and compares them whenever the DUT reports something.
module tb_aurora_os_detector;

    localparam int LEN = 3;

    localparam logic [3:0] NONE = 4'd0, K = 4'd1, R = 4'd2, A = 4'd3, I = 4'd4, P = 4'd5;
    localparam logic [3:0] SCP = 4'd6, ECP = 4'd7, CC = 4'd8, SUF = 4'd9, SNF = 4'd10;
    localparam logic [3:0] SP = 4'd11, SPA = 4'd12, VER = 4'd13;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_is_k = 1'b0, rx_valid = 1'b0, rx_err = 1'b0;
    logic [3:0] os_type;
    logic       os_valid, data_valid, err;
    logic [7:0] os_payload, data_out, err_cnt;

    aurora_os_detector #(.LANE_SEQ_LEN(LEN), .ERR_CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_is_k(rx_is_k), .rx_valid(rx_valid),
        .rx_err(rx_err), .os_type(os_type), .os_valid(os_valid), .os_payload(os_payload),
        .data_out(data_out), .data_valid(data_valid), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned at;
        logic        err;
        logic        osv;
        logic [3:0]  ost;
        logic [7:0]  pay;
        logic        dv;
        logic [7:0]  dat;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    logic [8:0]  pend[$];  // {is_k, byte} of the partially received ordered set
    int unsigned mcnt = 0;
    int          errors = 0, checks = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [3:0] lane_os(input logic [7:0] b);
        return (b == 8'h95) ? SP : (b == 8'hB5) ? SPA : VER;
    endfunction

    task automatic idle_dec(input logic [7:0] b, input logic k, inout exp_t e);
        if (!k) begin
            e.dv = 1'b1; e.dat = b;
        end else if (b == 8'h1C) begin e.osv = 1'b1; e.ost = R; end
        else if (b == 8'h7C) begin e.osv = 1'b1; e.ost = A; end
        else if (b == 8'h3C) begin e.osv = 1'b1; e.ost = I; end
        else if (b == 8'hF7) begin e.osv = 1'b1; e.ost = P; end
        else if (b == 8'hBC) begin e.osv = 1'b1; e.ost = K; pend.push_back({1'b1, b}); end
        else if (b inside {8'h5C, 8'hFD, 8'hFC, 8'h9C, 8'hDC}) pend.push_back({1'b1, b});
        else e.err = 1'b1;
    endtask

    task automatic model_step(input logic [7:0] b, input logic k, input logic er,
                              output exp_t e);
        logic [7:0] lead, second;
        logic [3:0] code;
        e = '{default: 0};
        e.at = cyc + 1;
        if (er) begin
            e.err = 1'b1;
            pend.delete();
        end else if (pend.size() == 0) begin
            idle_dec(b, k, e);
        end else begin
            lead = pend[0][7:0];
            if (lead == 8'hBC) begin
                if (k) begin
                    pend.delete();
                    idle_dec(b, k, e);
                end else if (pend.size() == 1 && !(b inside {8'h95, 8'hB5, 8'h4A})) begin
                    e.dv = 1'b1; e.dat = b;
                    pend.delete();
                end else if (pend.size() == 1 || b == pend[1][7:0]) begin
                    pend.push_back({1'b0, b});
                    if (pend.size() - 1 == LEN) begin
                        e.osv = 1'b1; e.ost = lane_os(b);
                        pend.delete();
                    end
                end else begin
                    e.err = 1'b1;
                    pend.delete();
                end
            end else if (lead == 8'h9C || lead == 8'hDC) begin
                pend.delete();
                if (!k) begin
                    e.osv = 1'b1; e.ost = (lead == 8'h9C) ? SUF : SNF; e.pay = b;
                end else begin
                    e.err = 1'b1;
                    idle_dec(b, k, e);
                end
            end else begin
                second = (lead == 8'h5C) ? 8'hFB : (lead == 8'hFD) ? 8'hFE : 8'hFC;
                code   = (lead == 8'h5C) ? SCP : (lead == 8'hFD) ? ECP : CC;
                pend.delete();
                if (k && b == second) begin
                    e.osv = 1'b1; e.ost = code;
                end else begin
                    e.err = 1'b1;
                    idle_dec(b, k, e);
                end
            end
        end
        if (e.err && mcnt < 255) mcnt++;
        e.cnt = 8'(mcnt);
    endtask

    task automatic send(input logic [7:0] b, input logic k, input logic er);
        exp_t e;
        @(negedge clk);
        rx_valid = 1'b1; rx_data = b; rx_is_k = k; rx_err = er;
        model_step(b, k, er, e);
        if (e.err || e.osv || e.dv) sb.push_back(e);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0; rx_data = 8'($urandom); rx_is_k = 1'($urandom);
            rx_err = 1'($urandom);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (os_valid || data_valid || err)) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got os_valid=%0b os_type=%0d data_valid=%0b err=%0b, expected no pulse",
                         os_valid, os_type, data_valid, err);
            end else begin
                e = sb.pop_front();
                chk("latency_cycle", cyc, e.at);
                chk("err", err, e.err);
                chk("os_valid", os_valid, e.osv);
                chk("os_type", os_type, e.osv ? e.ost : NONE);
                if (e.osv) chk("os_payload", os_payload, e.pay);
                chk("data_valid", data_valid, e.dv);
                if (e.dv) chk("data_out", data_out, e.dat);
                chk("err_cnt", err_cnt, e.cnt);
            end
        end
    end

    logic [7:0] klist[14] = '{8'h1C, 8'h7C, 8'h3C, 8'hF7, 8'hBC, 8'h5C, 8'hFB, 8'hFD,
                              8'hFE, 8'hFC, 8'h9C, 8'hDC, 8'h00, 8'h00};
    logic [7:0] lseq[3] = '{8'h95, 8'hB5, 8'h4A};

    initial begin
        logic [7:0] b;
        int         r;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_os_valid", os_valid, 0);
        chk("reset_os_type", os_type, NONE);
        chk("reset_err_cnt", err_cnt, 0);
        chk("reset_data_valid", data_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // SP with an idle gap inside the data run
        send(8'hBC, 1, 0); send(8'h95, 0, 0); gap(1); send(8'h95, 0, 0); send(8'h95, 0, 0);
        // SCP then data; broken SCP re-decodes the data char alongside err
        send(8'h5C, 1, 0); send(8'hFB, 1, 0); send(8'h12, 0, 0);
        send(8'h5C, 1, 0); send(8'h34, 0, 0);
        send(8'hFD, 1, 0); send(8'hFE, 1, 0); send(8'hFC, 1, 0); send(8'hFC, 1, 0);
        send(8'hDC, 1, 0); send(8'hA5, 0, 0); send(8'h9C, 1, 0); send(8'h1C, 1, 0);
        // rx_err inside SPA, then a clean SPA
        send(8'hBC, 1, 0); send(8'hB5, 0, 0); send(8'hB5, 0, 1); send(8'hB5, 0, 0);
        send(8'hBC, 1, 0); repeat (LEN) send(8'hB5, 0, 0);
        send(8'hBC, 1, 0); send(8'h4A, 0, 0); send(8'h95, 0, 0);
        gap(2);

        // Asynchronous reset in the middle of a lane sequence
        send(8'hBC, 1, 0); send(8'h95, 0, 0);
        @(negedge clk);
        rst_n = 1'b0; rx_valid = 1'b0;
        pend.delete(); mcnt = 0;
        #1;
        chk("midreset_os_valid", os_valid, 0);
        chk("midreset_os_type", os_type, NONE);
        chk("midreset_err", err, 0);
        chk("midreset_err_cnt", err_cnt, 0);
        chk("midreset_payload", os_payload, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(8'h95, 0, 0); send(8'h95, 0, 0); send(8'h95, 0, 0);

        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 6) gap($urandom_range(1, 3));
            else if (r < 10) send(8'($urandom), 1'($urandom), 1'b1);
            else if (r < 30) begin
                b = lseq[$urandom_range(0, 2)];
                send(8'hBC, 1, 0);
                for (int j = 0; j < LEN; j++) begin
                    if ($urandom_range(0, 9) == 0) gap(1);
                    if ($urandom_range(0, 11) == 0) send(lseq[$urandom_range(0, 2)], 0, 0);
                    else send(b, 0, 0);
                end
            end else if (r < 60) begin
                b = klist[$urandom_range(0, 13)];
                if (b == 8'h00) b = 8'($urandom);
                send(b, 1, 0);
            end else begin
                b = ($urandom_range(0, 2) == 0) ? lseq[$urandom_range(0, 2)] : 8'($urandom);
                send(b, 0, 0);
            end
        end

        repeat (300) send(8'($urandom), 1'($urandom), 1'b1);
        gap(3);
        chk("err_cnt_saturated", err_cnt, 255);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
